fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the team's FIFO among NUM_REQ requesters.
- Sits in the FIFO write-clock domain. Its wr_en_o/wdata_o drive the FIFO wr_en_i/wdata_i, and the FIFO full_o feeds back into full_i.
- Grants are burst-based: one owner holds the port for up to MAX_BURST accepted beats, then ownership rotates. This gives fairness and prevents starvation.

---
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter that shares one FIFO write port among
// NUM_REQ requesters. An owner keeps the port for up to MAX_BURST accepted
// beats, then ownership rotates. Lives in the FIFO write-clock domain.
// IDX_W must equal $clog2(NUM_REQ).
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] data_i,
    input  logic                     full_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic                     wr_en_o,
    output logic [WIDTH-1:0]         wdata_o,
    output logic [IDX_W-1:0]         owner_o,
    output logic                     busy_o
);

    // One spare bit so the counter can hold MAX_BURST without wrapping.
    localparam int                 CNT_W       = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]   LAST_BEAT   = CNT_W'(MAX_BURST - 1);
    // Starting from the highest index makes requester 0 win first after reset.
    localparam logic [IDX_W-1:0]   RESET_OWNER = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_wr_en;
    logic [WIDTH-1:0]   r_wdata;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_beat_cnt;

    state_t             w_nxt_state;
    logic [NUM_REQ-1:0] w_nxt_gnt;
    logic               w_nxt_wr_en;
    logic [WIDTH-1:0]   w_nxt_wdata;
    logic [IDX_W-1:0]   w_nxt_owner;
    logic [CNT_W-1:0]   w_nxt_beat_cnt;
    logic [NUM_REQ-1:0] w_ack;
    logic [IDX_W-1:0]   w_pick;
    logic               w_accept;
    logic [WIDTH-1:0]   w_owner_data;

    // First requester at or after last+1, wrapping modulo NUM_REQ. The search
    // walks the order backwards so the last hit kept is the first in order,
    // which leaves the previous owner with the lowest priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0]   last,
                                                 input logic [NUM_REQ-1:0] req);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (req[idx]) pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    assign w_pick       = rr_pick(r_owner, req_i);
    assign w_owner_data = data_i[int'(r_owner)*WIDTH +: WIDTH];
    // A beat is taken only from the granted owner and only while the FIFO has room.
    assign w_accept     = (r_state == ST_BURST) & r_gnt[r_owner] & req_i[r_owner] & ~full_i;

    // Next-state and datapath decode for the IDLE/BURST machine.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_nxt_state    = r_state;
        w_nxt_gnt      = r_gnt;
        w_nxt_wr_en    = 1'b0;
        w_nxt_wdata    = r_wdata;
        w_nxt_owner    = r_owner;
        w_nxt_beat_cnt = r_beat_cnt;
        w_ack          = '0;

        case (r_state)
            ST_IDLE: begin
                // Arbitration takes this one cycle; no beat is accepted here.
                if (|req_i) begin
                    w_nxt_state    = ST_BURST;
                    w_nxt_gnt      = NUM_REQ'(1) << w_pick;
                    w_nxt_owner    = w_pick;
                    w_nxt_beat_cnt = '0;
                end
            end
            ST_BURST: begin
                if (w_accept) begin
                    w_ack[r_owner] = 1'b1;
                    w_nxt_wr_en    = 1'b1;
                    w_nxt_wdata    = w_owner_data;
                    w_nxt_beat_cnt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_gnt   = '0;
                    end
                end else if (!full_i && !req_i[r_owner]) begin
                    // Owner gave up early; a drop seen while full waits for room.
                    w_nxt_state = ST_IDLE;
                    w_nxt_gnt   = '0;
                end
            end
        endcase
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_wr_en    <= 1'b0;
            r_wdata    <= '0;
            r_owner    <= RESET_OWNER;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_gnt      <= w_nxt_gnt;
            r_wr_en    <= w_nxt_wr_en;
            r_wdata    <= w_nxt_wdata;
            r_owner    <= w_nxt_owner;
            r_beat_cnt <= w_nxt_beat_cnt;
        end
    end

    assign gnt_o   = r_gnt;
    assign ack_o   = w_ack;
    assign wr_en_o = r_wr_en;
    assign wdata_o = r_wdata;
    assign owner_o = r_owner;
    assign busy_o  = (r_state == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter. Requesters are modelled as data
// queues that advance on ack; a round-robin burst model predicts the global
// write order and the burst list; a monitor checks every FIFO write and
// every completed grant against those predictions.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int WIDTH      = 8;
    localparam int MAX_BURST  = 4;
    localparam int IDX_W      = 2;
    localparam int FIFO_DEPTH = 16;

    typedef struct {
        int owner;
        int beats;
    } burst_t;

    logic                     clk_i   = 1'b0;
    logic                     rst_n_i = 1'b0;
    logic [NUM_REQ-1:0]       req_i   = '0;
    logic [NUM_REQ*WIDTH-1:0] data_i  = '0;
    logic                     full_i  = 1'b0;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       ack_o;
    logic                     wr_en_o;
    logic [WIDTH-1:0]         wdata_o;
    logic [IDX_W-1:0]         owner_o;
    logic                     busy_o;

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .MAX_BURST(MAX_BURST),
        .IDX_W    (IDX_W)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .req_i  (req_i),
        .data_i (data_i),
        .full_i (full_i),
        .gnt_o  (gnt_o),
        .ack_o  (ack_o),
        .wr_en_o(wr_en_o),
        .wdata_o(wdata_o),
        .owner_o(owner_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] src_q [NUM_REQ][$];
    logic [WIDTH-1:0] exp_wr_q [$];
    burst_t           exp_burst_q [$];

    logic use_fifo   = 1'b0;
    logic full_force = 1'b0;
    int   fifo_cnt   = 0;

    logic [NUM_REQ-1:0] s_gnt, s_ack;
    logic               s_wr, s_busy;
    logic [WIDTH-1:0]   s_wdata;
    logic [IDX_W-1:0]   s_owner;
    int                 s_cnt;

    logic [NUM_REQ-1:0] t1_gnt [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
    logic [NUM_REQ-1:0] t1_ack [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
    logic [NUM_REQ-1:0] t4_gnt [6]  = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Requesters present the head of their queue and hold req while data remains.
    task automatic drive_inputs();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_i[k] = (src_q[k].size() != 0);
            data_i[k*WIDTH +: WIDTH] = (src_q[k].size() != 0) ? src_q[k][0] : '0;
        end
        full_i = use_fifo ? (fifo_cnt == FIFO_DEPTH) : full_force;
    endtask

    // One clock: sample at the falling edge, then advance requesters and the
    // FIFO occupancy model just after the rising edge.
    task automatic cycle();
        @(negedge clk_i);
        s_gnt   = gnt_o;
        s_ack   = ack_o;
        s_wr    = wr_en_o;
        s_wdata = wdata_o;
        s_owner = owner_o;
        s_busy  = busy_o;
        s_cnt   = int'(dut.r_beat_cnt);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < NUM_REQ; k++)
            if (s_ack[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
        if (use_fifo) begin
            check("wr_while_full", {31'd0, s_wr && (fifo_cnt == FIFO_DEPTH)}, 32'd0);
            if (s_wr && fifo_cnt < FIFO_DEPTH) fifo_cnt++;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n_i    = 1'b0;
        use_fifo   = 1'b0;
        full_force = 1'b0;
        fifo_cnt   = 0;
        for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
        drive_inputs();
        repeat (2) cycle();
        rst_n_i = 1'b1;
    endtask

    // Round-robin burst model: starting after `last`, the next requester with
    // data gets min(MAX_BURST, remaining) beats. Stops once max_wr writes
    // would be exceeded, so a burst is predicted only if it can complete.
    task automatic model_load(input int last, input int max_wr);
        int rem [NUM_REQ];
        int pos [NUM_REQ];
        int owner;
        int total;
        int pick;
        int n;
        owner = last;
        total = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rem[k] = src_q[k].size();
            pos[k] = 0;
        end
        while (1) begin
            pick = -1;
            for (int s = 1; s <= NUM_REQ; s++) begin
                int k;
                k = (owner + s) % NUM_REQ;
                if (pick < 0 && rem[k] > 0) pick = k;
            end
            if (pick < 0) break;
            n = (rem[pick] < MAX_BURST) ? rem[pick] : MAX_BURST;
            if (total + n > max_wr) break;
            for (int j = 0; j < n; j++) exp_wr_q.push_back(src_q[pick][pos[pick] + j]);
            exp_burst_q.push_back('{owner: pick, beats: n});
            pos[pick] += n;
            rem[pick] -= n;
            total     += n;
            owner      = pick;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_wr_q.size() != 0 || exp_burst_q.size() != 0) && n < 400) begin
            cycle();
            n++;
        end
        check({name, "_pending"}, exp_wr_q.size() + exp_burst_q.size(), 32'd0);
    endtask

    // Monitor: every FIFO write and every completed grant is popped and compared.
    initial begin
        logic [WIDTH-1:0] exp_d;
        burst_t           b;
        logic             in_burst;
        int               m_owner;
        int               m_beats;
        in_burst = 1'b0;
        m_owner  = 0;
        m_beats  = 0;
        forever begin
            @(negedge clk_i);
            if (wr_en_o === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got wdata %0h, expected no write", wdata_o);
                end else begin
                    exp_d = exp_wr_q.pop_front();
                    check("wdata", wdata_o, exp_d);
                end
            end
            if (rst_n_i !== 1'b1) begin
                in_burst = 1'b0;
            end else if (gnt_o != '0) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    m_beats  = 0;
                    for (int k = 0; k < NUM_REQ; k++) if (gnt_o[k]) m_owner = k;
                end
                if (ack_o != '0) m_beats++;
            end else if (in_burst) begin
                in_burst = 1'b0;
                if (exp_burst_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_burst: got owner %0d beats %0d, expected none", m_owner, m_beats);
                end else begin
                    b = exp_burst_q.pop_front();
                    check("burst_owner", m_owner, b.owner);
                    check("burst_beats", m_beats, b.beats);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        do_reset();
        cycle();
        check("rst_gnt", s_gnt, 32'd0);
        check("rst_ack", s_ack, 32'd0);
        check("rst_wr_en", s_wr, 32'd0);
        check("rst_wdata", s_wdata, 32'd0);
        check("rst_owner", s_owner, NUM_REQ - 1);
        check("rst_busy", s_busy, 32'd0);
        check("rst_beat_cnt", s_cnt, 32'd0);

        // Single requester, six beats: burst of 4, one IDLE cycle, burst of 2.
        do_reset();
        for (int j = 0; j < 6; j++) src_q[0].push_back(WIDTH'(8'h10 + j));
        model_load(NUM_REQ - 1, 1000);
        drive_inputs();
        for (int c = 0; c < 10; c++) begin
            cycle();
            check("single_gnt", s_gnt, t1_gnt[c]);
            check("single_ack", s_ack, t1_ack[c]);
        end
        drain("single");

        // All four requesters, eight beats each.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++)
            for (int j = 0; j < 8; j++) src_q[k].push_back(WIDTH'(k*16 + j + $urandom_range(0, 1)*128));
        model_load(NUM_REQ - 1, 1000);
        drive_inputs();
        drain("round_robin");

        // Full stall at beat 2 of owner 2.
        do_reset();
        for (int j = 0; j < 4; j++) src_q[2].push_back(WIDTH'(8'h30 + j));
        model_load(NUM_REQ - 1, 1000);
        drive_inputs();
        repeat (3) cycle();
        full_force = 1'b1;
        drive_inputs();
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("stall_ack", s_ack, 32'd0);
            check("stall_gnt", s_gnt, 32'h4);
            check("stall_beat_cnt", s_cnt, 32'd2);
            if (c > 0) check("stall_wr_en", s_wr, 32'd0);
        end
        full_force = 1'b0;
        drive_inputs();
        cycle();
        check("resume_wr_en", s_wr, 32'd0);
        check("resume_ack_beat2", s_ack, 32'h4);
        cycle();
        check("resume_ack_beat3", s_ack, 32'h4);
        cycle();
        check("stall_release_gnt", s_gnt, 32'd0);
        drain("full_stall");

        // Early release by requester 1, then requester 3 after one IDLE cycle.
        do_reset();
        src_q[1].push_back(8'h20);
        src_q[1].push_back(8'h21);
        for (int j = 0; j < 3; j++) src_q[3].push_back(WIDTH'(8'h70 + j));
        model_load(NUM_REQ - 1, 1000);
        drive_inputs();
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("early_gnt", s_gnt, t4_gnt[c]);
        end
        drain("early_release");

        // Against a 16-deep FIFO that is never read: 16 writes, then a stall.
        do_reset();
        use_fifo = 1'b1;
        fifo_cnt = 0;
        for (int k = 0; k < NUM_REQ; k++)
            for (int j = 0; j < 5; j++) src_q[k].push_back(WIDTH'($urandom_range(0, 255)));
        model_load(NUM_REQ - 1, FIFO_DEPTH);
        drive_inputs();
        drain("fifo");
        repeat (10) cycle();
        check("fifo_writes", fifo_cnt, FIFO_DEPTH);
        check("fifo_full", full_i, 32'd1);
        check("fifo_stall_gnt", s_gnt, 32'h1);
        check("fifo_stall_ack", s_ack, 32'd0);
        check("fifo_stall_wr_en", s_wr, 32'd0);

        // Reset in the middle of a burst by owner 1.
        do_reset();
        for (int j = 0; j < 4; j++) src_q[1].push_back(WIDTH'(8'h40 + j));
        exp_wr_q.push_back(8'h40);
        exp_wr_q.push_back(8'h41);
        drive_inputs();
        repeat (3) cycle();
        rst_n_i = 1'b0;
        cycle();
        rst_n_i = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
        src_q[0].push_back(8'h50);
        src_q[0].push_back(8'h51);
        src_q[1].push_back(8'h60);
        model_load(NUM_REQ - 1, 1000);
        drive_inputs();
        cycle();
        check("midrst_gnt", s_gnt, 32'd0);
        check("midrst_wr_en", s_wr, 32'd0);
        check("midrst_wdata", s_wdata, 32'd0);
        check("midrst_owner", s_owner, NUM_REQ - 1);
        check("midrst_busy", s_busy, 32'd0);
        cycle();
        check("midrst_regrant", s_gnt, 32'h1);
        drain("mid_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
